// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: 50% duty (odd or even divisor) or
// one-cycle pulse output, a period-start tick, and glitch-free divisor updates.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_wr,
   output logic             div_ack,
   output logic             div_err,
   output logic [WIDTH-1:0] div_cur,
   output logic             clk_out,
   output logic             tick
);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH-1:0] pend_reg;
   logic [WIDTH-1:0] hi_reg;
   logic             pend_flag_reg;
   logic             run_reg;
   logic             a_reg;
   logic             b_reg;
   logic             half_reg;
   logic             tick_reg;
   logic             ack_reg;
   logic             err_reg;

   logic [WIDTH-1:0] last_cnt;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] hi_next;
   logic             start;
   logic             apply;
   logic             wr_ok;
   logic             wr_bad;

   assign last_cnt = div_reg - WIDTH'(1);
   assign cnt_inc  = cnt_reg + WIDTH'(1);
   assign start    = en & (~run_reg | (cnt_reg == last_cnt));
   // Queued divisor lands on a period boundary, or immediately while stopped.
   assign apply    = pend_flag_reg & (~en | start);
   assign wr_bad   = div_wr & (div_in < WIDTH'(2));
   assign wr_ok    = div_wr & ~wr_bad;
   assign div_next = apply ? pend_reg : div_reg;
   // High cycles of A: floor(D/2) in square mode, the odd half-cycle comes from B.
   assign hi_next  = mode ? WIDTH'(1) : (div_next >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg       <= '0;
         div_reg       <= WIDTH'(DEFAULT_DIV);
         pend_reg      <= '0;
         pend_flag_reg <= 1'b0;
         hi_reg        <= '0;
         run_reg       <= 1'b0;
         a_reg         <= 1'b0;
         half_reg      <= 1'b0;
         tick_reg      <= 1'b0;
         ack_reg       <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         ack_reg <= apply;
         err_reg <= wr_bad;
         if (apply) begin
            div_reg <= pend_reg;
         end
         // A write coinciding with a boundary stays pending for the next one.
         if (wr_ok) begin
            pend_reg      <= div_in;
            pend_flag_reg <= 1'b1;
         end else if (apply) begin
            pend_flag_reg <= 1'b0;
         end
         if (!en) begin
            run_reg  <= 1'b0;
            cnt_reg  <= '0;
            a_reg    <= 1'b0;
            half_reg <= 1'b0;
            tick_reg <= 1'b0;
         end else if (start) begin
            run_reg  <= 1'b1;
            cnt_reg  <= '0;
            a_reg    <= 1'b1;
            tick_reg <= 1'b1;
            hi_reg   <= hi_next;
            half_reg <= ~mode & div_next[0];
         end else begin
            cnt_reg  <= cnt_inc;
            a_reg    <= (cnt_inc < hi_reg);
            tick_reg <= 1'b0;
         end
      end
   end

   // Half-cycle extension for odd divisors in square mode.
   always_ff @(negedge clk) begin
      if (rst) begin
         b_reg <= 1'b0;
      end else begin
         b_reg <= a_reg & half_reg;
      end
   end

   assign clk_out = a_reg | (b_reg & run_reg);
   assign tick    = tick_reg;
   assign div_ack = ack_reg;
   assign div_err = err_reg;
   assign div_cur = div_reg;

endmodule
